// File: rtl/plasma_pll_rst_seq_pkg.sv
// plasma_rst_seq_pkg: shared state encoding, retry counter width and counter width helper for the PLL reset sequencer
package plasma_rst_seq_pkg;
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;
  localparam int RETRY_W = 8;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/plasma_pll_rst_seq_if.sv
// plasma_pll_rst_seq_if: sequencer bus (pll_locked/soft_rst_req in; pll_rst, domain_rst, all_ready, retry_count, state out); master = sequencer, slave = environment
interface plasma_pll_rst_seq_if
  import plasma_rst_seq_pkg::*;
#(parameter int NUM_DOMAINS = 2);
  logic                   pll_locked;
  logic                   soft_rst_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   all_ready;
  logic [RETRY_W-1:0]     retry_count;
  logic [2:0]             state;
  modport master(input pll_locked, soft_rst_req, output pll_rst, domain_rst, all_ready, retry_count, state);
  modport slave(output pll_locked, soft_rst_req, input pll_rst, domain_rst, all_ready, retry_count, state);
endinterface

// File: rtl/plasma_pll_rst_seq_sync_bit.sv
// plasma_sync_bit: STAGES-deep single-bit synchroniser (clk, async active-high rst to 0, d_i in, q_o out)
module plasma_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/plasma_pll_rst_seq.sv
// plasma_pll_rst_seq: PLL supervisor and staggered domain reset sequencer (refclk, async rst, bus = master side of plasma_pll_rst_seq_if)
module plasma_pll_rst_seq
  import plasma_rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 2,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input logic                  refclk,
  input logic                  rst,
  plasma_pll_rst_seq_if.master bus
);
  localparam logic [2:0] PLL_RST   = S_PLL_RST;
  localparam logic [2:0] WAIT_LOCK = S_WAIT_LOCK;
  localparam logic [2:0] STABLE    = S_STABLE;
  localparam logic [2:0] RELEASE   = S_RELEASE;
  localparam logic [2:0] RUN       = S_RUN;
  localparam int PW = cnt_w(PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES);
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int GW = cnt_w(STAGGER_CYCLES);
  localparam int IW = cnt_w(NUM_DOMAINS);
  localparam logic [PW-1:0] RST_LAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [PW-1:0] TMO_LAST = PW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] STG_LAST = GW'(STAGGER_CYCLES - 1);
  logic                   locked_s;
  logic [2:0]             state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [SW-1:0]          stable_q, stable_d;
  logic [GW-1:0]          stagger_q, stagger_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  plasma_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(refclk),
    .rst(rst),
    .d_i(bus.pll_locked),
    .q_o(locked_s)
  );
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    stable_d  = stable_q;
    stagger_d = stagger_q;
    idx_d     = idx_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    retry_d   = retry_q;
    if (bus.soft_rst_req) begin
      state_d   = PLL_RST;
      phase_d   = '0;
      pll_rst_d = 1'b1;
      dom_d     = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          phase_d   = (phase_q == RST_LAST) ? '0 : phase_q + 1'b1;
          state_d   = (phase_q == RST_LAST) ? WAIT_LOCK : PLL_RST;
          pll_rst_d = (phase_q != RST_LAST);
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d  = STABLE;
            stable_d = '0;
          end else if (phase_q == TMO_LAST) begin
            state_d   = PLL_RST;
            phase_d   = '0;
            pll_rst_d = 1'b1;
            retry_d   = retry_q + {{(RETRY_W-1){1'b0}}, ~&retry_q};
          end else phase_d = phase_q + 1'b1;
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            phase_d = '0;
          end else if (stable_q == STB_LAST) begin
            state_d   = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            dom_d     = {NUM_DOMAINS{1'b1}} << 1;
            idx_d     = '0;
            stagger_d = '0;
          end else stable_d = stable_q + 1'b1;
        end
        RELEASE, RUN: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            phase_d = '0;
            dom_d   = '1;
            ready_d = 1'b0;
          end else if (state_q == RUN) ready_d = 1'b1;
          else if (stagger_q == STG_LAST) begin
            // shifting a zero in from the bottom releases domains strictly in ascending order
            stagger_d = '0;
            idx_d     = idx_q + 1'b1;
            dom_d     = dom_q << 1;
            state_d   = (int'(idx_q) == NUM_DOMAINS - 2) ? RUN : RELEASE;
          end else stagger_d = stagger_q + 1'b1;
        end
        default: begin
          state_d   = PLL_RST;
          phase_d   = '0;
          pll_rst_d = 1'b1;
          dom_d     = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      phase_q   <= '0;
      stable_q  <= '0;
      stagger_q <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stable_q  <= stable_d;
      stagger_q <= stagger_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      retry_q   <= retry_d;
    end
  end
  assign bus.pll_rst     = pll_rst_q;
  assign bus.domain_rst  = dom_q;
  assign bus.all_ready   = ready_q;
  assign bus.retry_count = retry_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_plasma_pll_rst_seq.sv
// tb_plasma_pll_rst_seq: directed self-checking bench for plasma_pll_rst_seq
module tb_plasma_pll_rst_seq;
  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   vecs   = 0;
  int   errs   = 0;
  plasma_pll_rst_seq_if #(.NUM_DOMAINS(3)) bus();
  plasma_pll_rst_seq #(
    .NUM_DOMAINS(3),
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .STAGGER_CYCLES(3),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );
  always #5 refclk = ~refclk;
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_rst_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #2;
    vecs++; if (bus.pll_rst !== 1'b1) begin errs++; $display("FAIL rst_pll_rst: got %b want 1", bus.pll_rst); end
    vecs++; if (bus.domain_rst !== 3'b111) begin errs++; $display("FAIL rst_domain_rst: got %b want 111", bus.domain_rst); end
    vecs++; if (bus.all_ready !== 1'b0) begin errs++; $display("FAIL rst_all_ready: got %b want 0", bus.all_ready); end
    vecs++; if (bus.retry_count !== 8'd0) begin errs++; $display("FAIL rst_retry: got %0d want 0", bus.retry_count); end
    vecs++; if (bus.state !== 3'd0) begin errs++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    tick(1);
    rst = 1'b0;
    tick(3);
    vecs++; if (bus.pll_rst !== 1'b1) begin errs++; $display("FAIL rst_pulse_e3: got %b want 1", bus.pll_rst); end
    tick(1);
    vecs++; if (bus.pll_rst !== 1'b0) begin errs++; $display("FAIL rst_pulse_e4: got %b want 0", bus.pll_rst); end
    vecs++; if (bus.state !== 3'd1) begin errs++; $display("FAIL rst_wait_lock: got %0d want 1", bus.state); end
  endtask
  task automatic test_bringup();
    do_reset();
    tick(10);
    bus.pll_locked = 1'b1;
    tick(10);
    vecs++; if (bus.domain_rst !== 3'b111) begin errs++; $display("FAIL up_dom_e10: got %b want 111", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b110) begin errs++; $display("FAIL up_dom_e11: got %b want 110", bus.domain_rst); end
    vecs++; if (bus.state !== 3'd3) begin errs++; $display("FAIL up_state_release: got %0d want 3", bus.state); end
    tick(2);
    vecs++; if (bus.domain_rst !== 3'b110) begin errs++; $display("FAIL up_dom_e13: got %b want 110", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b100) begin errs++; $display("FAIL up_dom_e14: got %b want 100", bus.domain_rst); end
    tick(2);
    vecs++; if (bus.domain_rst !== 3'b100) begin errs++; $display("FAIL up_dom_e16: got %b want 100", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b000) begin errs++; $display("FAIL up_dom_e17: got %b want 000", bus.domain_rst); end
    vecs++; if (bus.all_ready !== 1'b0) begin errs++; $display("FAIL up_ready_e17: got %b want 0", bus.all_ready); end
    vecs++; if (bus.state !== 3'd4) begin errs++; $display("FAIL up_state_run: got %0d want 4", bus.state); end
    tick(1);
    vecs++; if (bus.all_ready !== 1'b1) begin errs++; $display("FAIL up_ready_e18: got %b want 1", bus.all_ready); end
  endtask
  task automatic test_timeout();
    do_reset();
    for (int e = 1; e <= 9252; e++) begin
      tick(1);
      if (e == 35) begin
        vecs++; if (bus.pll_rst !== 1'b0 || bus.retry_count !== 8'd0) begin errs++; $display("FAIL tmo_e35: got rst=%b cnt=%0d want rst=0 cnt=0", bus.pll_rst, bus.retry_count); end
      end
      if (e == 36 || e == 72 || e == 108) begin
        vecs++; if (bus.pll_rst !== 1'b1 || bus.state !== 3'd0 || bus.retry_count !== 8'(e / 36)) begin errs++; $display("FAIL tmo_e%0d: got rst=%b st=%0d cnt=%0d want rst=1 st=0 cnt=%0d", e, bus.pll_rst, bus.state, bus.retry_count, e / 36); end
      end
      if (e == 39) begin
        vecs++; if (bus.pll_rst !== 1'b1) begin errs++; $display("FAIL tmo_e39: got %b want 1", bus.pll_rst); end
      end
      if (e == 40) begin
        vecs++; if (bus.pll_rst !== 1'b0 || bus.state !== 3'd1) begin errs++; $display("FAIL tmo_e40: got rst=%b st=%0d want rst=0 st=1", bus.pll_rst, bus.state); end
      end
      if (e == 9179) begin
        vecs++; if (bus.retry_count !== 8'd254) begin errs++; $display("FAIL tmo_e9179: got %0d want 254", bus.retry_count); end
      end
      if (e == 9180 || e == 9252) begin
        vecs++; if (bus.retry_count !== 8'd255) begin errs++; $display("FAIL tmo_sat_e%0d: got %0d want 255", e, bus.retry_count); end
      end
    end
  endtask
  task automatic test_debounce();
    do_reset();
    tick(10);
    bus.pll_locked = 1'b1;
    tick(6);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    vecs++; if (bus.state !== 3'd2) begin errs++; $display("FAIL deb_state_r8: got %0d want 2", bus.state); end
    tick(1);
    vecs++; if (bus.state !== 3'd1) begin errs++; $display("FAIL deb_state_r9: got %0d want 1", bus.state); end
    tick(1);
    vecs++; if (bus.state !== 3'd2) begin errs++; $display("FAIL deb_state_r10: got %0d want 2", bus.state); end
    tick(7);
    vecs++; if (bus.domain_rst !== 3'b111) begin errs++; $display("FAIL deb_dom_f10: got %b want 111", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b110) begin errs++; $display("FAIL deb_dom_f11: got %b want 110", bus.domain_rst); end
  endtask
  task automatic test_lock_loss();
    do_reset();
    tick(10);
    bus.pll_locked = 1'b1;
    tick(20);
    vecs++; if (bus.all_ready !== 1'b1) begin errs++; $display("FAIL loss_pre_ready: got %b want 1", bus.all_ready); end
    bus.pll_locked = 1'b0;
    tick(2);
    vecs++; if (bus.domain_rst !== 3'b000) begin errs++; $display("FAIL loss_dom_e2: got %b want 000", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b111 || bus.all_ready !== 1'b0) begin errs++; $display("FAIL loss_e3: got dom=%b rdy=%b want dom=111 rdy=0", bus.domain_rst, bus.all_ready); end
    vecs++; if (bus.pll_rst !== 1'b0 || bus.state !== 3'd1) begin errs++; $display("FAIL loss_pll: got rst=%b st=%0d want rst=0 st=1", bus.pll_rst, bus.state); end
    bus.pll_locked = 1'b1;
    tick(5);
    vecs++; if (bus.pll_rst !== 1'b0) begin errs++; $display("FAIL loss_pll_l5: got %b want 0", bus.pll_rst); end
    tick(5);
    vecs++; if (bus.domain_rst !== 3'b111) begin errs++; $display("FAIL loss_dom_l10: got %b want 111", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.domain_rst !== 3'b110) begin errs++; $display("FAIL loss_dom_l11: got %b want 110", bus.domain_rst); end
    tick(3);
    vecs++; if (bus.domain_rst !== 3'b100) begin errs++; $display("FAIL loss_dom_l14: got %b want 100", bus.domain_rst); end
    tick(3);
    vecs++; if (bus.domain_rst !== 3'b000) begin errs++; $display("FAIL loss_dom_l17: got %b want 000", bus.domain_rst); end
    tick(1);
    vecs++; if (bus.all_ready !== 1'b1) begin errs++; $display("FAIL loss_ready_l18: got %b want 1", bus.all_ready); end
  endtask
  task automatic test_soft_reset();
    do_reset();
    tick(36);
    vecs++; if (bus.retry_count !== 8'd1) begin errs++; $display("FAIL soft_pre_retry: got %0d want 1", bus.retry_count); end
    bus.pll_locked = 1'b1;
    tick(13);
    vecs++; if (bus.domain_rst !== 3'b110 || bus.state !== 3'd3) begin errs++; $display("FAIL soft_pre_release: got dom=%b st=%0d want dom=110 st=3", bus.domain_rst, bus.state); end
    bus.soft_rst_req = 1'b1;
    tick(1);
    bus.soft_rst_req = 1'b0;
    vecs++; if (bus.domain_rst !== 3'b111 || bus.state !== 3'd0) begin errs++; $display("FAIL soft_e1: got dom=%b st=%0d want dom=111 st=0", bus.domain_rst, bus.state); end
    vecs++; if (bus.pll_rst !== 1'b1 || bus.all_ready !== 1'b0) begin errs++; $display("FAIL soft_pll_e1: got rst=%b rdy=%b want rst=1 rdy=0", bus.pll_rst, bus.all_ready); end
    vecs++; if (bus.retry_count !== 8'd1) begin errs++; $display("FAIL soft_retry: got %0d want 1", bus.retry_count); end
    tick(3);
    vecs++; if (bus.pll_rst !== 1'b1) begin errs++; $display("FAIL soft_pll_e4: got %b want 1", bus.pll_rst); end
    tick(1);
    vecs++; if (bus.pll_rst !== 1'b0 || bus.state !== 3'd1) begin errs++; $display("FAIL soft_pll_e5: got rst=%b st=%0d want rst=0 st=1", bus.pll_rst, bus.state); end
  endtask
  task automatic test_async_rst();
    do_reset();
    tick(36);
    bus.pll_locked = 1'b1;
    tick(25);
    vecs++; if (bus.all_ready !== 1'b1 || bus.retry_count !== 8'd1) begin errs++; $display("FAIL arst_pre: got rdy=%b cnt=%0d want rdy=1 cnt=1", bus.all_ready, bus.retry_count); end
    #2;
    rst = 1'b1;
    #1;
    vecs++; if (bus.pll_rst !== 1'b1 || bus.domain_rst !== 3'b111) begin errs++; $display("FAIL arst_out: got rst=%b dom=%b want rst=1 dom=111", bus.pll_rst, bus.domain_rst); end
    vecs++; if (bus.all_ready !== 1'b0 || bus.retry_count !== 8'd0 || bus.state !== 3'd0) begin errs++; $display("FAIL arst_misc: got rdy=%b cnt=%0d st=%0d want rdy=0 cnt=0 st=0", bus.all_ready, bus.retry_count, bus.state); end
    tick(2);
    rst = 1'b0;
  endtask
  initial begin
    bus.pll_locked = 1'b0;
    bus.soft_rst_req = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_debounce();
    test_lock_loss();
    test_soft_reset();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
